// File: rtl/iq_symbol_sched.sv
// I/Q modulator sequencer: PLL bring-up FSM, symbol FIFO and periodic symbol playout.
// Optional IQSCHED_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module iq_symbol_sched #(
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 1024,
  parameter int PLLRST_CYC = 4,
  parameter int PER_W      = 16
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             locked,
  output logic             pll_areset,
  output logic             pll_ena,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  input  logic [7:0]       sym_i,
  input  logic [7:0]       sym_q,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [7:0]       i,
  output logic [7:0]       q,
  output logic             sym_strobe,
  output logic             running,
  output logic             underrun
`ifdef IQSCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int RW = $clog2(PLLRST_CYC + 1);
  localparam logic [7:0] IDLE_I = 8'd127;
  localparam logic [7:0] IDLE_Q = 8'd0;

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, SETTLE, RUN} state_t;

  state_t           state;
  logic [RW-1:0]    rst_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [PER_W-1:0] sym_cnt;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic full, empty, flush, slot, do_push, do_pop, underrun_evt;

  // Losing lock while running flushes the FIFO and wins over a same-cycle push.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign flush        = (state == RUN) && !locked;
  assign slot         = (state == RUN) && locked && enable && (sym_cnt == '0);
  assign do_pop       = slot && !empty;
  assign underrun_evt = slot && empty;
  assign sym_ready    = !full && (state != PLL_RST);
  assign do_push      = sym_valid && sym_ready && !flush;
  assign running      = (state == RUN);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {sym_i, sym_q};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= PLL_RST;
      pll_areset <= 1'b1;
      pll_ena    <= 1'b0;
      rst_cnt    <= '0;
      settle_cnt <= '0;
      sym_cnt    <= '0;
      i          <= IDLE_I;
      q          <= IDLE_Q;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        PLL_RST: begin
          pll_areset <= 1'b1;
          pll_ena    <= 1'b1;
          i          <= IDLE_I;
          q          <= IDLE_Q;
          if (rst_cnt == RW'(PLLRST_CYC - 1)) begin
            state      <= WAIT_LOCK;
            pll_areset <= 1'b0;
            rst_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        WAIT_LOCK: begin
          pll_areset <= 1'b0;
          i          <= IDLE_I;
          q          <= IDLE_Q;
          if (locked) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          i <= IDLE_I;
          q <= IDLE_Q;
          if (!locked) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            state   <= RUN;
            sym_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        RUN: begin
          if (!locked) begin
            state <= WAIT_LOCK;
            i     <= IDLE_I;
            q     <= IDLE_Q;
          end else if (!enable) begin
            sym_cnt <= '0;
            i       <= IDLE_I;
            q       <= IDLE_Q;
          end else if (slot) begin
            sym_cnt <= period;
            if (!empty) begin
              i          <= mem[rd_ptr][15:8];
              q          <= mem[rd_ptr][7:0];
              sym_strobe <= 1'b1;
            end else begin
              i        <= IDLE_I;
              q        <= IDLE_Q;
              underrun <= 1'b1;
            end
          end else begin
            sym_cnt <= sym_cnt - PER_W'(1);
          end
        end
        default: state <= PLL_RST;
      endcase

      // Occupancy tracks push and pop independently so a simultaneous pair nets to zero.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

`ifdef IQSCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      underrun_cnt <= '0;
    end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iq_symbol_sched.sv
// Self-checking bench for iq_symbol_sched: table-driven playout vectors plus
// hand sequences for bring-up, full FIFO, lock loss and reset; data checked by a scoreboard.
module tb_iq_symbol_sched;

  logic        clk;
  logic        reset_;
  logic        locked;
  logic        pll_areset;
  logic        pll_ena;
  logic        enable;
  logic [15:0] period;
  logic [7:0]  sym_i;
  logic [7:0]  sym_q;
  logic        sym_valid;
  logic        sym_ready;
  logic [7:0]  dut_i;
  logic [7:0]  dut_q;
  logic        sym_strobe;
  logic        running;
  logic        underrun;
`ifdef IQSCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] period;
    logic [7:0]  i0;
    logic [7:0]  q0;
    logic [7:0]  i1;
    logic [7:0]  q1;
    int          exp_gap;
  } vec_t;

  vec_t vecs[5];

  iq_symbol_sched dut (
    .clk          (clk),
    .reset_       (reset_),
    .locked       (locked),
    .pll_areset   (pll_areset),
    .pll_ena      (pll_ena),
    .enable       (enable),
    .period       (period),
    .sym_i        (sym_i),
    .sym_q        (sym_q),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .i            (dut_i),
    .q            (dut_q),
    .sym_strobe   (sym_strobe),
    .running      (running),
    .underrun     (underrun)
`ifdef IQSCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must carry the oldest accepted symbol; underruns carry the idle carrier.
  always @(negedge clk) begin
    if (reset_ && sym_strobe) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got i=%0d q=%0d, required no strobe", dut_i, dut_q);
      end else begin
        check_output("strobe_data", {16'd0, dut_i, dut_q}, {16'd0, sb_q.pop_front()});
      end
    end
    if (reset_ && underrun)
      check_output("underrun_idle", {16'd0, dut_i, dut_q}, 32'h7F00);
  end

  task automatic check_reset_values();
    check_output("rst_pll_areset", pll_areset, 1);
    check_output("rst_pll_ena", pll_ena, 0);
    check_output("rst_sym_ready", sym_ready, 0);
    check_output("rst_i", dut_i, 127);
    check_output("rst_q", dut_q, 0);
    check_output("rst_strobe", sym_strobe, 0);
    check_output("rst_running", running, 0);
    check_output("rst_underrun", underrun, 0);
`ifdef IQSCHED_UNDERRUN_CNT_EN
    check_output("rst_underrun_cnt", underrun_cnt, 0);
`endif
  endtask

  task automatic apply_stimulus_reset();
    reset_    = 1'b0;
    locked    = 1'b0;
    sym_valid = 1'b0;
    enable    = 1'b0;
    #1;
    check_reset_values();
    sb_q.delete();
    tick();
    tick();
  endtask

  task automatic wait_running(input int exp_n, input string name);
    int n;
    bit idle_ok;
    n = 0;
    idle_ok = 1'b1;
    while (!running && n < 3000) begin
      tick();
      n++;
      if (!running && (dut_i != 8'd127 || dut_q != 8'd0)) idle_ok = 1'b0;
    end
    check_output(name, n, exp_n);
    check_output({name, "_idle"}, idle_ok, 1);
  endtask

  task automatic push_sym(input logic [7:0] pi, input logic [7:0] pq);
    int w;
    w = 0;
    sym_i = pi;
    sym_q = pq;
    sym_valid = 1'b1;
    while (!sym_ready && w < 2000) begin
      tick();
      w++;
    end
    if (!sym_ready) begin
      check_output("push_ready", sym_ready, 1);
    end else begin
      tick();
      sb_q.push_back({pi, pq});
    end
    sym_valid = 1'b0;
  endtask

  initial begin
    int n, ns, nu;
    reset_    = 1'b1;
    locked    = 1'b0;
    enable    = 1'b0;
    period    = 16'd0;
    sym_i     = 8'd0;
    sym_q     = 8'd0;
    sym_valid = 1'b0;

    vecs[0] = '{16'd0,  8'd1,   8'd2,   8'd3,   8'd4,   1};
    vecs[1] = '{16'd1,  8'd200, 8'd100, 8'd50,  8'd25,  2};
    vecs[2] = '{16'd3,  8'd10,  8'd20,  8'd30,  8'd40,  4};
    vecs[3] = '{16'd7,  8'hFF,  8'h00,  8'h00,  8'hFF,  8};
    vecs[4] = '{16'd20, 8'h5A,  8'hA5,  8'h11,  8'h22, 21};

    #2;
    apply_stimulus_reset();

    // Bring-up: pll_areset width, then lock at cycle 10 and the full settle time.
    reset_ = 1'b1;
    n = 0;
    while (pll_areset && n < 20) begin
      n++;
      tick();
    end
    check_output("pll_areset_width", n, 4);
    check_output("pll_ena_on", pll_ena, 1);
    repeat (6) tick();
    locked = 1'b1;
    wait_running(1025, "settle_first");

    // Table-driven playout: two symbols, strobe spacing, then an underrun slot.
    for (int k = 0; k < 5; k++) begin
      enable = 1'b0;
      period = vecs[k].period;
      push_sym(vecs[k].i0, vecs[k].q0);
      push_sym(vecs[k].i1, vecs[k].q1);
      check_output("disabled_idle", {24'd0, dut_i}, 127);
      enable = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!sym_strobe && n < 50);
      check_output("first_slot", n, 1);
      n = 0;
      do begin tick(); n++; end while (!sym_strobe && n < 100);
      check_output("strobe_gap", n, vecs[k].exp_gap);
      n = 0;
      do begin tick(); n++; end while (!underrun && n < 100);
      check_output("underrun_gap", n, vecs[k].exp_gap);
      enable = 1'b0;
      tick();
    end

    // Push landing in the same cycle as a slot on an empty FIFO underruns; symbol plays next slot.
    period = 16'd0;
    enable = 1'b1;
    tick();
    sym_i = 8'd55;
    sym_q = 8'd66;
    sym_valid = 1'b1;
    tick();
    sb_q.push_back({8'd55, 8'd66});
    sym_valid = 1'b0;
    check_output("nofall_underrun", underrun, 1);
    check_output("nofall_strobe", sym_strobe, 0);
    tick();
    check_output("nofall_next_strobe", sym_strobe, 1);
    enable = 1'b0;
    tick();

    // Full FIFO: ready drops after the 8th push and the held 9th enters right after the first pop.
    period = 16'd100;
    for (int k = 0; k < 8; k++) push_sym(8'(100 + k), 8'(200 - k));
    check_output("full_ready", sym_ready, 0);
    sym_i = 8'd9;
    sym_q = 8'd99;
    sym_valid = 1'b1;
    repeat (3) tick();
    check_output("full_held", sym_ready, 0);
    enable = 1'b1;
    tick();
    check_output("full_pop_strobe", sym_strobe, 1);
    check_output("full_pop_ready", sym_ready, 1);
    tick();
    sb_q.push_back({8'd9, 8'd99});
    sym_valid = 1'b0;
    check_output("ninth_accepted", sym_ready, 0);
    n = 0;
    while (sb_q.size() != 0 && n < 1200) begin
      tick();
      n++;
    end
    check_output("drain_empty", sb_q.size(), 0);
    enable = 1'b0;
    tick();

    // Lock loss in RUN with 3 queued: flush beats the same-cycle push, idle carrier next clk.
    period = 16'd100;
    for (int k = 0; k < 4; k++) push_sym(8'(60 + k), 8'(70 + k));
    enable = 1'b1;
    tick();
    check_output("flush_pre_strobe", sym_strobe, 1);
    check_output("flush_pre_i", dut_i, 60);
    repeat (2) tick();
    locked = 1'b0;
    sym_i = 8'd77;
    sym_q = 8'd88;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    sb_q.delete();
    check_output("flush_running", running, 0);
    check_output("flush_iq", {16'd0, dut_i, dut_q}, 32'h7F00);
    check_output("flush_ready", sym_ready, 1);
    period = 16'd0;
    locked = 1'b1;
    wait_running(1025, "relock_settle");
    ns = 0;
    nu = 0;
    repeat (10) begin
      tick();
      if (sym_strobe) ns++;
      if (underrun) nu++;
    end
    check_output("relock_strobes", ns, 0);
    check_output("relock_underruns", nu, 10);
    enable = 1'b0;

    // Lock loss during SETTLE restarts the full settle period.
    apply_stimulus_reset();
    reset_ = 1'b1;
    repeat (10) tick();
    locked = 1'b1;
    repeat (500) tick();
    check_output("settle_partial_running", running, 0);
    locked = 1'b0;
    repeat (5) tick();
    check_output("settle_drop_running", running, 0);
    locked = 1'b1;
    wait_running(1025, "settle_restart");

    // Asynchronous reset mid-operation discards queued symbols.
    enable = 1'b0;
    period = 16'd5;
    push_sym(8'd1, 8'd1);
    push_sym(8'd2, 8'd2);
    #1;
    reset_ = 1'b0;
    #1;
    check_reset_values();
    sb_q.delete();
    tick();
    tick();
    reset_ = 1'b1;
    locked = 1'b1;
    period = 16'd0;
    wait_running(1029, "rerun_settle");
    enable = 1'b1;
    ns = 0;
    repeat (6) begin
      tick();
      if (sym_strobe) ns++;
    end
    check_output("after_reset_strobes", ns, 0);
    enable = 1'b0;

`ifdef IQSCHED_UNDERRUN_CNT_EN
    // Underrun counter: 20 empty slots at period 0, cleared only by reset.
    apply_stimulus_reset();
    reset_ = 1'b1;
    locked = 1'b1;
    period = 16'd0;
    wait_running(1029, "cnt_settle");
    check_output("cnt_start", underrun_cnt, 0);
    enable = 1'b1;
    repeat (20) tick();
    enable = 1'b0;
    repeat (2) tick();
    check_output("cnt_twenty", underrun_cnt, 20);
    reset_ = 1'b0;
    #1;
    check_output("cnt_reset", underrun_cnt, 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
